// File: rtl/memory_dump_serializer_pkg.sv
// Shared debug package: dump FSM state encoding and default dump geometry.
// Also used by the debug UART command decoder.
package memory_dump_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } dump_state_t;

    localparam int DBG_WORDS  = 32;
    localparam int DBG_WORD_W = 32;

    // Number of bytes in a full debug image
    function automatic int dump_bytes(input int words, input int word_w);
        return (words * word_w) / 8;
    endfunction

    localparam int DUMP_BYTES = dump_bytes(DBG_WORDS, DBG_WORD_W);
    localparam int DUMP_CNT_W = $clog2(DUMP_BYTES);

endpackage

// File: rtl/memory_dump_serializer.sv
// Captures the flattened memory debug image on request and streams it out
// big-endian (word 0 first, MSB byte first) over a valid/ready byte link.
module memory_dump_serializer
    import memory_dump_serializer_pkg::*;
#(
    parameter int WORDS  = DBG_WORDS,
    parameter int WORD_W = DBG_WORD_W
) (
    input  logic                    clk,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic [WORDS*WORD_W-1:0] i_mem_snapshot,
    output logic [7:0]              o_tx_data,
    output logic                    o_tx_valid,
    input  logic                    i_tx_ready,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam int IMG_W  = WORDS * WORD_W;
    localparam int NBYTES = dump_bytes(WORDS, WORD_W);
    localparam int CNT_W  = $clog2(NBYTES);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

    dump_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [IMG_W-1:0] shreg_q;
    logic             load;
    logic             accept;

    // Outputs depend only on registered state, so ready never reaches valid
    assign accept    = o_tx_valid && i_tx_ready;
    assign o_tx_data = shreg_q[IMG_W-1 -: 8];

    // State register
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d    = state_q;
        o_tx_valid = 1'b0;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        load       = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    load    = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                o_tx_valid = 1'b1;
                o_busy     = 1'b1;
                if (accept && (cnt_q == LAST_BYTE)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                o_busy  = 1'b1;
                o_done  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Private image copy and byte counter; shifting exposes the next byte
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (load) begin
            shreg_q <= i_mem_snapshot;
            cnt_q   <= '0;
        end else if (accept) begin
            shreg_q <= {shreg_q[IMG_W-9:0], 8'h00};
            cnt_q   <= cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_memory_dump_serializer.sv
// Bench for memory_dump_serializer: table-driven dumps plus hand-written
// sequences for stall, isolation, mid-dump reset and held start.
module tb_memory_dump_serializer;

    localparam int WORDS  = 32;
    localparam int WORD_W = 32;
    localparam int NB     = WORDS * WORD_W / 8;

    logic                    clk;
    logic                    i_reset;
    logic                    i_start;
    logic [WORDS*WORD_W-1:0] i_mem_snapshot;
    logic [7:0]              o_tx_data;
    logic                    o_tx_valid;
    logic                    i_tx_ready;
    logic                    o_busy;
    logic                    o_done;

    memory_dump_serializer #(.WORDS(WORDS), .WORD_W(WORD_W)) dut (
        .clk            (clk),
        .i_reset        (i_reset),
        .i_start        (i_start),
        .i_mem_snapshot (i_mem_snapshot),
        .o_tx_data      (o_tx_data),
        .o_tx_valid     (o_tx_valid),
        .i_tx_ready     (i_tx_ready),
        .o_busy         (o_busy),
        .o_done         (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          done_cnt = 0;
    logic [7:0]  exp_q[$];
    logic [31:0] words[WORDS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Flatten words[] with word 0 in the MSBs
    task automatic build_snapshot();
        for (int i = 0; i < WORDS; i++)
            i_mem_snapshot[(WORDS-1-i)*WORD_W +: WORD_W] = words[i];
    endtask

    // Expected byte stream: word 0 first, each word MSB byte first
    task automatic push_expected();
        for (int k = 0; k < NB; k++) begin
            logic [31:0] w;
            w = words[k / 4] >> (8 * (3 - (k % 4)));
            exp_q.push_back(w[7:0]);
        end
    endtask

    function automatic logic ready_fn(input int mode, input int cyc);
        if (mode == 1) return !(cyc == 2 || cyc == 3);
        return 1'b1;
    endfunction

    // Scoreboard monitor: pops on accept, checks hold-stable during stalls
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    always @(negedge clk) begin
        if (prev_stall) begin
            check("stall_valid_hold", {31'b0, o_tx_valid}, 32'd1);
            check("stall_data_hold", {24'b0, o_tx_data}, {24'b0, prev_data});
        end
        if (o_tx_valid && i_tx_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_byte", {24'b0, o_tx_data}, 32'hFFFF_FFFF);
            end else begin
                check("byte", {24'b0, o_tx_data}, {24'b0, exp_q.pop_front()});
            end
        end
        if (o_done) done_cnt++;
        prev_stall = o_tx_valid && !i_tx_ready;
        prev_data  = o_tx_data;
    end

    // Start edge happens at the next posedge; returns #1 into cycle 1
    task automatic start_dump(input logic hold);
        @(posedge clk); #1;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = hold;
        check("cycle1_valid", {31'b0, o_tx_valid}, 32'd1);
        check("cycle1_busy", {31'b0, o_busy}, 32'd1);
    endtask

    // Runs cycles from cycle 1 until o_done; ev_kind 1 = isolation, 2 = reset
    task automatic wait_done(input int mode, input int ev_cyc, input int ev_kind, output int cd);
        cd = -2;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            i_tx_ready = ready_fn(mode, cyc);
            if (ev_kind == 1 && cyc == ev_cyc) begin
                words[0] = 32'hFFFF_FFFF;
                build_snapshot();
                i_start = 1'b1;
            end
            if (ev_kind == 1 && cyc == ev_cyc + 1) i_start = 1'b0;
            if (ev_kind == 2 && cyc == ev_cyc) begin
                i_reset = 1'b1;
                #1;
                check("async_rst_valid", {31'b0, o_tx_valid}, 32'd0);
                check("async_rst_busy", {31'b0, o_busy}, 32'd0);
                check("async_rst_data", {24'b0, o_tx_data}, 32'd0);
                exp_q.delete();
                cd = -1;
                return;
            end
            @(negedge clk);
            if (o_done) begin
                cd = cyc;
                return;
            end
            @(posedge clk); #1;
        end
        check("done_timeout", 32'd0, 32'd1);
    endtask

    // Busy falls the cycle after done, and the stream must be fully consumed
    task automatic after_done();
        @(posedge clk); #1;
        check("idle_busy", {31'b0, o_busy}, 32'd0);
        check("idle_valid", {31'b0, o_tx_valid}, 32'd0);
        check("queue_drained", exp_q.size(), 32'd0);
    endtask

    typedef struct {
        int          widx;
        logic [31:0] wval;
        int          rmode;
        int          exp_done;
    } vec_t;

    initial begin
        vec_t vecs[3];
        int   cd;
        int   exp_dones;

        // Reset held with start high: nothing may happen
        i_reset = 1'b1;
        i_start = 1'b1;
        i_tx_ready = 1'b1;
        i_mem_snapshot = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {31'b0, o_tx_valid}, 32'd0);
        check("rst_busy", {31'b0, o_busy}, 32'd0);
        check("rst_done", {31'b0, o_done}, 32'd0);
        check("rst_data", {24'b0, o_tx_data}, 32'd0);
        i_start = 1'b0;
        @(posedge clk); #1;
        i_reset = 1'b0;

        // Backpressure row: valid spans cycles 1..130, done lands in 131
        vecs[0] = '{widx: 0,  wval: 32'h1122_3344, rmode: 0, exp_done: 129};
        vecs[1] = '{widx: 31, wval: 32'hDEAD_BEEF, rmode: 0, exp_done: 129};
        vecs[2] = '{widx: 0,  wval: 32'hA1B2_C3D4, rmode: 1, exp_done: 131};
        exp_dones = 0;
        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < WORDS; i++) words[i] = 32'h0;
            words[vecs[v].widx] = vecs[v].wval;
            build_snapshot();
            push_expected();
            start_dump(1'b0);
            wait_done(vecs[v].rmode, 0, 0, cd);
            check($sformatf("vec%0d_done_cycle", v), cd, vecs[v].exp_done);
            exp_dones++;
            after_done();
            check($sformatf("vec%0d_done_count", v), done_cnt, exp_dones);
        end

        // Snapshot change and start pulse at byte 10 have no effect
        for (int i = 0; i < WORDS; i++) words[i] = 32'(i + 1) * 32'h0101_0101;
        build_snapshot();
        push_expected();
        start_dump(1'b0);
        wait_done(0, 10, 1, cd);
        check("isolate_done_cycle", cd, 32'd129);
        exp_dones++;
        after_done();
        check("isolate_done_count", done_cnt, exp_dones);

        // Reset at byte 50 aborts without o_done; restart uses a fresh image
        for (int i = 0; i < WORDS; i++) words[i] = $urandom;
        build_snapshot();
        push_expected();
        start_dump(1'b0);
        wait_done(0, 50, 2, cd);
        repeat (2) @(posedge clk);
        #1;
        i_reset = 1'b0;
        check("abort_no_done", done_cnt, exp_dones);
        for (int i = 0; i < WORDS; i++) words[i] = $urandom;
        build_snapshot();
        push_expected();
        start_dump(1'b0);
        wait_done(0, 0, 0, cd);
        check("restart_done_cycle", cd, 32'd129);
        exp_dones++;
        after_done();
        check("restart_done_count", done_cnt, exp_dones);

        // Start held high: next dump begins on the IDLE cycle after DONE
        for (int i = 0; i < WORDS; i++) words[i] = 32'hC0DE_0000 | 32'(i);
        build_snapshot();
        push_expected();
        push_expected();
        start_dump(1'b1);
        wait_done(0, 0, 0, cd);
        check("held1_done_cycle", cd, 32'd129);
        @(posedge clk); #1;
        check("held_idle_valid", {31'b0, o_tx_valid}, 32'd0);
        check("held_idle_busy", {31'b0, o_busy}, 32'd0);
        @(posedge clk); #1;
        i_start = 1'b0;
        check("held_restart_valid", {31'b0, o_tx_valid}, 32'd1);
        wait_done(0, 0, 0, cd);
        check("held2_done_cycle", cd, 32'd129);
        exp_dones += 2;
        after_done();
        check("held_done_count", done_cnt, exp_dones);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
